jtdsp16_do_ctrl: RTL

Do-loop sequencer for the DSP16 core; sits directly upstream of the ROM address arithmetic unit (XAAU). It decodes `do K {NI}` and `redo K` once they retire, counts the first pass fetched from ROM, then replays the cached body K-1 times. It drives the XAAU loop strobes (`do_save`, `do_start`, `do_redo`, `do_out`, `do_short`) and the cache index `do_pc`.

---
 rtl/jtdsp16_do_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jtdsp16_do_ctrl.sv
// Do-loop sequencer for the DSP16 core. Decodes retired `do K {NI}` and
// `redo K`, counts the first pass fetched from ROM, then replays the cached
// body from index 0 until all K iterations have retired. Strobes are
// combinational so the XAAU samples them on the same edge as the step.
module jtdsp16_do_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        step,
  input  logic        do_en,
  input  logic        redo_en,
  input  logic [10:0] do_data,
  output logic        do_save,
  output logic        do_start,
  output logic        do_redo,
  output logic        do_out,
  output logic        do_short,
  output logic [3:0]  do_pc,
  output logic        busy,
  output logic        incache,
  output logic        cache_ok
);

  typedef enum logic [1:0] {IDLE, FILL, LOOP} state_t;

  state_t     state, state_nxt;
  logic [3:0] ni, ni_nxt;
  logic [6:0] rem, rem_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic [3:0] pc_nxt;
  logic       cok_nxt;
  logic       adv;
  logic [3:0] d_ni;
  logic [6:0] d_k;
  logic [3:0] ni_last;

  assign adv     = step & cen;
  assign d_ni    = do_data[10:7];
  assign d_k     = do_data[6:0];
  assign ni_last = ni - 4'd1;

  assign do_short = (ni == 4'd1);
  assign busy     = (state != IDLE);
  assign incache  = (state == LOOP);

  // Next-state and strobe decode; everything idles unless a qualified step arrives
  always_comb begin
    state_nxt = state;
    ni_nxt    = ni;
    rem_nxt   = rem;
    fcnt_nxt  = fcnt;
    pc_nxt    = do_pc;
    cok_nxt   = cache_ok;
    do_save   = 1'b0;
    do_start  = 1'b0;
    do_redo   = 1'b0;
    do_out    = 1'b0;
    case (state)
      IDLE: begin
        if (adv) begin
          if (do_en && d_ni != 4'd0 && d_k != 7'd0) begin
            do_save   = 1'b1;
            ni_nxt    = d_ni;
            rem_nxt   = d_k - 7'd1;
            fcnt_nxt  = 4'd0;
            state_nxt = FILL;
          end else if (redo_en && cache_ok && d_k != 7'd0) begin
            // Replay the cached body: all K passes come from the cache
            do_start  = 1'b1;
            do_redo   = 1'b1;
            rem_nxt   = d_k;
            pc_nxt    = 4'd0;
            state_nxt = LOOP;
          end
        end
      end
      FILL: begin
        if (adv) begin
          fcnt_nxt = fcnt + 4'd1;
          if (fcnt == ni_last) begin
            cok_nxt = 1'b1;
            if (rem == 7'd0) begin
              do_out    = 1'b1;
              state_nxt = IDLE;
            end else begin
              do_start  = 1'b1;
              pc_nxt    = 4'd0;
              state_nxt = LOOP;
            end
          end
        end
      end
      LOOP: begin
        if (adv) begin
          if (do_pc < ni_last) begin
            pc_nxt = do_pc + 4'd1;
          end else begin
            pc_nxt = 4'd0;
            if (rem > 7'd1) begin
              rem_nxt = rem - 7'd1;
            end else begin
              do_out    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; cen gates every update, reset drops a loop in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ni       <= 4'd0;
      rem      <= 7'd0;
      fcnt     <= 4'd0;
      do_pc    <= 4'd0;
      cache_ok <= 1'b0;
    end else if (cen) begin
      state    <= state_nxt;
      ni       <= ni_nxt;
      rem      <= rem_nxt;
      fcnt     <= fcnt_nxt;
      do_pc    <= pc_nxt;
      cache_ok <= cok_nxt;
    end
  end

endmodule
